riscv_csr_unit: RTL and testbench

Zicsr/Zicntr register file for the RV32 core. Executes CSRRW/RS/RC and the immediate forms against FFLAGS, FRM, FCSR, CYCLE/TIME/INSTRET and their high halves. Sits in the execute/writeback stage beside the ALU: decode supplies the CSR fields, the block returns a registered read value for rd, and it raises an illegal flag for bad accesses. It also keeps the 64-bit counters and accrues floating-point exception flags.

---
 rtl/riscv_csr_unit_pkg.sv | 44 ++++
 rtl/riscv_csr_unit_if.sv | 27 ++
 rtl/riscv_counter64.sv | 23 ++
 rtl/riscv_csr_unit.sv | 156 +++++++++++++++
 tb/tb_riscv_csr_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_csr_unit_pkg.sv
// Shared types for the RV32 Zicsr/Zicntr CSR unit: op encodings, CSR addresses,
// FP field widths and the accrued-exception flag layout.
package riscv_csr_unit_pkg;

  localparam int unsigned RISCV_XLEN = 32;
  localparam int unsigned FFLAGS_LEN = 5;
  localparam int unsigned FRM_LEN    = 3;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_op_e;

  typedef enum logic [11:0] {
    CSR_FFLAGS   = 12'h001,
    CSR_FRM      = 12'h002,
    CSR_FCSR     = 12'h003,
    CSR_MCYCLE   = 12'hB00,
    CSR_MTIME    = 12'hB01,
    CSR_MINSTRET = 12'hB02,
    CSR_MCYCLEH  = 12'hB80,
    CSR_MTIMEH   = 12'hB81,
    CSR_MINSTRETH= 12'hB82,
    CSR_CYCLE    = 12'hC00,
    CSR_TIME     = 12'hC01,
    CSR_INSTRET  = 12'hC02,
    CSR_CYCLEH   = 12'hC80,
    CSR_TIMEH    = 12'hC81,
    CSR_INSTRETH = 12'hC82
  } csr_address_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

endpackage

// File: rtl/riscv_csr_unit_if.sv
// CSR request/response bundle between decode/execute (master) and the CSR unit (slave).
interface riscv_csr_unit_if
  import riscv_csr_unit_pkg::*;
#(
  parameter int unsigned XLEN = RISCV_XLEN
) ();

  logic            csr_valid;
  logic [11:0]     csr_addr;
  logic [2:0]      csr_funct3;
  logic [XLEN-1:0] csr_rs1_data;
  logic [4:0]      csr_rs1_field;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_rvalid;
  logic            csr_illegal;

  modport master (
    output csr_valid, csr_addr, csr_funct3, csr_rs1_data, csr_rs1_field,
    input  csr_rdata, csr_rvalid, csr_illegal
  );

  modport slave (
    input  csr_valid, csr_addr, csr_funct3, csr_rs1_data, csr_rs1_field,
    output csr_rdata, csr_rvalid, csr_illegal
  );

endinterface

// File: rtl/riscv_counter64.sv
// 64-bit event counter with independent 32-bit half loads; a load beats the increment.
module riscv_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic [31:0] load_data,
  output logic [63:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load_lo || load_hi) begin
      value <= {load_hi ? load_data : value[63:32],
                load_lo ? load_data : value[31:0]};
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/riscv_csr_unit.sv
// RV32 Zicsr/Zicntr CSR file: FFLAGS/FRM/FCSR plus CYCLE/TIME/INSTRET counters.
// Define CSR_COUNTER_WRITE_EN to expose the counters as writable at 0xB00-0xB82.
module riscv_csr_unit
  import riscv_csr_unit_pkg::*;
#(
  parameter int unsigned TIME_DIV = 1,
  parameter int unsigned XLEN     = RISCV_XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_csr_unit_if.slave       csr,
  input  logic                  retire,
  input  logic [FFLAGS_LEN-1:0] fflags_set,
  input  logic                  fflags_valid,
  output logic [FRM_LEN-1:0]    frm
);

  logic            req_valid;
  logic            req_wr;
  logic [11:0]     req_addr;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_src;

  fflags_t            fflags_q;
  logic [FRM_LEN-1:0] frm_q;
  logic [31:0]        presc;
  logic               presc_wrap;
  logic [63:0]        cycle_val, time_val, instret_val, cnt_val;
  logic [2:0]         cnt_ld_lo, cnt_ld_hi;

  logic               cnt_page, is_cnt, known, illegal_c, do_wr;
  logic               fflags_wr, frm_wr;
  logic [XLEN-1:0]    old_val, wr_val;

  // Access is captured here and executed on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_op    <= '0;
      req_src   <= '0;
    end else begin
      req_valid <= csr.csr_valid;
      req_wr    <= (csr.csr_funct3[1:0] == 2'b01) || (csr.csr_rs1_field != '0);
      req_addr  <= csr.csr_addr;
      req_op    <= csr.csr_funct3[1:0];
      req_src   <= csr.csr_funct3[2] ? XLEN'(csr.csr_rs1_field) : csr.csr_rs1_data;
    end
  end

  always_comb begin
    cnt_page = (req_addr[11:8] == 4'hC);
`ifdef CSR_COUNTER_WRITE_EN
    cnt_page = cnt_page || (req_addr[11:8] == 4'hB);
`endif
    is_cnt = cnt_page && (req_addr[6:2] == '0) && (req_addr[1:0] != 2'b11);

    case (req_addr[1:0])
      2'd0:    cnt_val = cycle_val;
      2'd1:    cnt_val = time_val;
      default: cnt_val = instret_val;
    endcase

    known   = 1'b1;
    old_val = '0;
    if (is_cnt) begin
      old_val = req_addr[7] ? XLEN'(cnt_val[63:32]) : XLEN'(cnt_val[31:0]);
    end else begin
      case (req_addr)
        CSR_FFLAGS: old_val = XLEN'(fflags_q);
        CSR_FRM:    old_val = XLEN'(frm_q);
        CSR_FCSR:   old_val = XLEN'({frm_q, fflags_q});
        default:    known   = 1'b0;
      endcase
    end

    illegal_c = req_valid && (!known || (req_op == 2'b00) ||
                              (req_wr && (req_addr[11:10] == 2'b11)));
    do_wr     = req_valid && !illegal_c && req_wr;

    case (req_op)
      2'b01:   wr_val = req_src;
      2'b10:   wr_val = old_val | req_src;
      default: wr_val = old_val & ~req_src;
    endcase

    fflags_wr = do_wr && ((req_addr == CSR_FFLAGS) || (req_addr == CSR_FCSR));
    frm_wr    = do_wr && ((req_addr == CSR_FRM) || (req_addr == CSR_FCSR));

    for (int unsigned i = 0; i < 3; i++) begin
      cnt_ld_lo[i] = do_wr && is_cnt && !req_addr[7] && (req_addr[1:0] == 2'(i));
      cnt_ld_hi[i] = do_wr && is_cnt &&  req_addr[7] && (req_addr[1:0] == 2'(i));
    end
  end

  // Same-edge accrual ORs on top of any software write to the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_q <= '0;
      frm_q    <= '0;
    end else begin
      fflags_q <= (fflags_wr ? wr_val[FFLAGS_LEN-1:0] : fflags_q) |
                  (fflags_valid ? fflags_set : '0);
      if (frm_wr) begin
        frm_q <= (req_addr == CSR_FCSR) ? wr_val[7:5] : wr_val[FRM_LEN-1:0];
      end
    end
  end

  assign frm        = frm_q;
  assign presc_wrap = (presc == TIME_DIV - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (cnt_ld_lo[1] || cnt_ld_hi[1] || presc_wrap) begin
      presc <= '0;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  riscv_counter64 u_cycle (
    .clk(clk), .rst_n(rst_n), .inc(1'b1),
    .load_lo(cnt_ld_lo[0]), .load_hi(cnt_ld_hi[0]), .load_data(wr_val[31:0]),
    .value(cycle_val)
  );

  riscv_counter64 u_time (
    .clk(clk), .rst_n(rst_n), .inc(presc_wrap),
    .load_lo(cnt_ld_lo[1]), .load_hi(cnt_ld_hi[1]), .load_data(wr_val[31:0]),
    .value(time_val)
  );

  riscv_counter64 u_instret (
    .clk(clk), .rst_n(rst_n), .inc(retire),
    .load_lo(cnt_ld_lo[2]), .load_hi(cnt_ld_hi[2]), .load_data(wr_val[31:0]),
    .value(instret_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr.csr_rdata   <= '0;
      csr.csr_rvalid  <= 1'b0;
      csr.csr_illegal <= 1'b0;
    end else begin
      csr.csr_rvalid  <= req_valid;
      csr.csr_illegal <= illegal_c;
      if (req_valid) begin
        csr.csr_rdata <= illegal_c ? '0 : old_val;
      end
    end
  end

endmodule

// File: tb/tb_riscv_csr_unit.sv
// Directed self-checking bench for riscv_csr_unit (TIME_DIV=4); follows CSR_COUNTER_WRITE_EN.
module tb_riscv_csr_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       retire = 1'b0;
    logic [4:0] fflags_set = '0;
    logic       fflags_valid = 1'b0;
    logic [2:0] frm;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned edges = 0;

    logic [31:0] rd;
    logic        ill;
    int unsigned e;
    int unsigned e_w;

    riscv_csr_unit_if #(.XLEN(32)) csr_bus ();

    riscv_csr_unit #(.TIME_DIV(4), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr          (csr_bus),
        .retire       (retire),
        .fflags_set   (fflags_set),
        .fflags_valid (fflags_valid),
        .frm          (frm)
    );

    always #5 clk = ~clk;

    // Reference edge count: CYCLE after k post-reset edges equals k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Returns rdata/illegal and the edge count seen when the result was sampled.
    task automatic csr_op(input logic [11:0] addr, input logic [2:0] f3,
                          input logic [31:0] rs1d, input logic [4:0] fld,
                          output logic [31:0] rdata, output logic illegal,
                          output int unsigned at);
        @(negedge clk);
        csr_bus.csr_valid     = 1'b1;
        csr_bus.csr_addr      = addr;
        csr_bus.csr_funct3    = f3;
        csr_bus.csr_rs1_data  = rs1d;
        csr_bus.csr_rs1_field = fld;
        @(negedge clk);
        csr_bus.csr_valid = 1'b0;
        @(negedge clk);
        check("rvalid_set", 32'(csr_bus.csr_rvalid), 32'd1);
        rdata   = csr_bus.csr_rdata;
        illegal = csr_bus.csr_illegal;
        at      = edges;
        @(negedge clk);
        check("rvalid_pulse", 32'(csr_bus.csr_rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        csr_bus.csr_valid     = 1'b0;
        csr_bus.csr_addr      = '0;
        csr_bus.csr_funct3    = '0;
        csr_bus.csr_rs1_data  = '0;
        csr_bus.csr_rs1_field = '0;

        repeat (3) @(negedge clk);
        check("rst_rdata",   csr_bus.csr_rdata, 32'd0);
        check("rst_rvalid",  32'(csr_bus.csr_rvalid), 32'd0);
        check("rst_illegal", 32'(csr_bus.csr_illegal), 32'd0);
        check("rst_frm",     32'(frm), 32'd0);
        rst_n = 1'b1;

        // Valid sampled on edge 11, result on edge 12 holds CYCLE=11.
        repeat (10) @(posedge clk);
        csr_op(12'hC00, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("cycle_first", rd, 32'd11);
        check("cycle_first_ill", 32'(ill), 32'd0);

        csr_op(12'h003, 3'b101, 32'd0, 5'h1F, rd, ill, e);
        check("fcsr_rwi_old", rd, 32'd0);
        csr_op(12'h002, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("frm_after_fcsr", rd, 32'd0);
        csr_op(12'h001, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("fflags_after_fcsr", rd, 32'h1F);
        check("frm_port_0", 32'(frm), 32'd0);

        csr_op(12'h002, 3'b101, 32'd0, 5'd5, rd, ill, e);
        check("frm_rwi_old", rd, 32'd0);
        check("frm_port_5", 32'(frm), 32'd5);
        csr_op(12'h002, 3'b001, 32'hFFFF_FFFE, 5'd3, rd, ill, e);
        check("frm_rw_old", rd, 32'd5);
        check("frm_port_6", 32'(frm), 32'd6);
        csr_op(12'h003, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("fcsr_read", rd, 32'hDF);

        // Accrual overlapping both the capture and the write edge.
        @(negedge clk);
        fflags_valid = 1'b1;
        fflags_set   = 5'h04;
        csr_op(12'h001, 3'b001, 32'd1, 5'd1, rd, ill, e);
        fflags_valid = 1'b0;
        fflags_set   = '0;
        check("fflags_rw_old", rd, 32'h1F);
        csr_op(12'h001, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("fflags_accrue_merge", rd, 32'h05);

        csr_op(12'h001, 3'b111, 32'd0, 5'd1, rd, ill, e);
        check("fflags_rci_old", rd, 32'h05);
        csr_op(12'h001, 3'b010, 32'hFF, 5'd0, rd, ill, e);
        check("fflags_rs_x0_read", rd, 32'h04);
        csr_op(12'h001, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("fflags_rs_x0_nowrite", rd, 32'h04);

        @(negedge clk);
        fflags_valid = 1'b1;
        fflags_set   = 5'h10;
        @(negedge clk);
        fflags_valid = 1'b0;
        fflags_set   = '0;
        csr_op(12'h001, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("fflags_accrue_only", rd, 32'h14);

        csr_op(12'hC00, 3'b001, 32'd1, 5'd1, rd, ill, e);
        check("cycle_write_ill", 32'(ill), 32'd1);
        check("cycle_write_rdata", rd, 32'd0);
        csr_op(12'hC00, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("cycle_unaffected", rd, 32'(e - 1));
        check("cycle_read_legal", 32'(ill), 32'd0);

        csr_op(12'h300, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("unknown_addr_ill", 32'(ill), 32'd1);
        csr_op(12'h001, 3'b000, 32'd0, 5'd0, rd, ill, e);
        check("funct3_000_ill", 32'(ill), 32'd1);
        csr_op(12'h001, 3'b100, 32'h1F, 5'h1F, rd, ill, e);
        check("funct3_100_ill", 32'(ill), 32'd1);
        check("funct3_100_rdata", rd, 32'd0);
        csr_op(12'hC02, 3'b011, 32'd0, 5'd1, rd, ill, e);
        check("instret_rc_ill", 32'(ill), 32'd1);
        csr_op(12'h001, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("fflags_after_ill", rd, 32'h14);

        csr_op(12'hC01, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("time_div4", rd, 32'((e - 1) / 4));
        csr_op(12'hC81, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("timeh", rd, 32'd0);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk) retire = 1'b1;
            @(negedge clk) retire = 1'b0;
        end
        csr_op(12'hC02, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("instret_7", rd, 32'd7);
        csr_op(12'hC82, 3'b110, 32'd0, 5'd0, rd, ill, e);
        check("instreth_0", rd, 32'd0);
        csr_op(12'hC80, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("cycleh_0", rd, 32'd0);

`ifdef CSR_COUNTER_WRITE_EN
        csr_op(12'hB80, 3'b001, 32'd0, 5'd1, rd, ill, e);
        check("mcycleh_wr_legal", 32'(ill), 32'd0);
        csr_op(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'd1, rd, ill, e_w);
        check("mcycle_wr_legal", 32'(ill), 32'd0);
        csr_op(12'hC80, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("cycleh_after_wrap", rd, 32'd1);
        csr_op(12'hC00, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("cycle_lo_after_wrap", rd, 32'(e - e_w - 2));
`else
        csr_op(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'd1, rd, ill, e);
        check("mcycle_wr_ill", 32'(ill), 32'd1);
        check("mcycle_wr_rdata", rd, 32'd0);
        csr_op(12'hB80, 3'b010, 32'd0, 5'd0, rd, ill, e);
        check("mcycleh_rd_ill", 32'(ill), 32'd1);
`endif

        // Reset lands between capture and execute: the response must vanish.
        @(negedge clk);
        csr_bus.csr_valid     = 1'b1;
        csr_bus.csr_addr      = 12'h002;
        csr_bus.csr_funct3    = 3'b101;
        csr_bus.csr_rs1_field = 5'd7;
        @(negedge clk);
        csr_bus.csr_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rvalid", 32'(csr_bus.csr_rvalid), 32'd0);
        check("midrst_frm", 32'(frm), 32'd0);
        check("midrst_rdata", csr_bus.csr_rdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("postrst_rvalid", 32'(csr_bus.csr_rvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
